stream_to_ram_ring: RTL and testbench
=====================================

STREAM_TO_RAM_RING -- requirements
Module: stream_to_ram_ring

Interface
REQ-001 Parameters, one per line:
- DW, 512, stream and AXI data width in bits; multiple of 64.
- BURST_BEATS, 64, beats per block/burst; range 1..256.
- BASE_ADDR, 64'h0, byte address of block 0.
- BANK_BLOCKS, 1024, blocks in the RAM region; at least 1.
- WRAP_MODE, 0, 0 = stop when region full; 1 = circular overwrite.
- MAX_OUTSTANDING, 8, maximum AW handshakes awaiting a B response.
- FIFO_DEPTH, 256, data FIFO depth in beats; at least 2*BURST_BEATS.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk  in  1  sole clock.
- sys_reset  in  1  reset; synchronous, active-high.
- enable  in  1  allows new AW issue.
- AXIS_IN_TDATA  in  DW  input beat.
- AXIS_IN_TVALID  in  1  input valid.
- AXIS_IN_TREADY  out  1  input ready.
- M_AXI_AWADDR  out  64  burst address.
- M_AXI_AWLEN/AWSIZE/AWBURST  out  8/3/2  constants: BURST_BEATS-1, log2(DW/8), INCR.
- M_AXI_AWVALID  out  1; M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  DW; M_AXI_WSTRB  out  DW/8, all ones.
- M_AXI_WVALID  out  1; M_AXI_WLAST  out  1; M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1.
- ram_blocks_written  out  32  B handshakes since reset.
- wrap_count  out  32  address wrap-arounds since reset.
- bresp_errors  out  16  B responses with BRESP != 0; saturates at 16'hFFFF.
- out_of_ram  out  1  region full (stop mode only).
REQ-003 The block is a write-only master; there are no read-channel ports, and AWID/LOCK/CACHE/QOS/PROT are left to the top level.

Function
REQ-004 Input beats are buffered in a FIFO of depth FIFO_DEPTH.
REQ-005 AXIS_IN_TREADY = FIFO not full and not sys_reset, and in WRAP_MODE=0 also beats accepted < BANK_BLOCKS*BURST_BEATS.
REQ-006 blocks_in increments on the accept handshake of each BURST_BEATS-th beat; a partial block is never written.
REQ-007 AW FSM has two states, IDLE and ADDR.
- IDLE->ADDR when all hold: enable=1; aw_issued < blocks_in; outstanding < MAX_OUTSTANDING; and (WRAP_MODE=1 or aw_issued < BANK_BLOCKS).
- ADDR asserts AWVALID with AWADDR held stable until AWREADY.
- On AW handshake: aw_issued++; go to IDLE.
REQ-008 AWVALID asserts on the cycle after the handshake that completes a block, provided all other IDLE->ADDR conditions are already true.
REQ-009 After each AW handshake, AWADDR += BURST_BEATS*DW/8. When the block index reaches BANK_BLOCKS, AWADDR returns to BASE_ADDR and wrap_count increments (WRAP_MODE=1 only).
REQ-010 outstanding: +1 on AW handshake, -1 on B handshake; unchanged when both occur in the same cycle.
REQ-011 W FSM has two states, IDLE and BURST.
- IDLE->BURST when w_issued < aw_issued.
- BURST: WVALID = FIFO output valid; beat counter advances on each W handshake; WLAST = (beat == BURST_BEATS-1).
- On the WLAST handshake: w_issued++; if w_issued+1 < aw_issued, start the next burst with no idle cycle; otherwise go to IDLE.
REQ-012 M_AXI_BREADY = not sys_reset. Each B handshake increments ram_blocks_written (32-bit wrap); error responses count too.
REQ-013 out_of_ram = (WRAP_MODE=0 and ram_blocks_written == BANK_BLOCKS); it is constant 0 when WRAP_MODE=1.
REQ-014 enable=0 blocks new AW issue only. An AW already in ADDR, all W bursts already granted, and input acceptance all continue.

Reset
REQ-015 While sys_reset=1 on a clk edge, the following are cleared: all counters to 0; both FSMs to IDLE; FIFO flushed; AWADDR to BASE_ADDR; AWVALID, WVALID, AXIS_IN_TREADY and BREADY to 0; outputs read 0.
REQ-016 Reset mid-burst abandons the burst immediately; WLAST is not completed.

Verification
REQ-017 DW=64, BURST_BEATS=4, BANK_BLOCKS=2, WRAP_MODE=0; 12 beats offered -> 8 accepted; AW at BASE, BASE+32; TREADY then held low; after 2 B responses out_of_ram=1.
REQ-018 Same parameters, WRAP_MODE=1; 12 beats -> AW at BASE, +32, BASE; wrap_count=1; out_of_ram stays 0.
REQ-019 MAX_OUTSTANDING=2, BVALID held low, 4 blocks supplied -> exactly 2 AW handshakes; the 3rd AW issues the cycle after the first B handshake.
REQ-020 WREADY always 1, 2 blocks present -> 8 consecutive WVALID beats, WLAST on beats 4 and 8, no gap between bursts.
REQ-021 BRESP=2'b10 on one response -> bresp_errors=1 and ram_blocks_written=1; simultaneous AW and B handshakes leave outstanding unchanged.
REQ-022 sys_reset asserted on beat 2 of a burst -> next cycle WVALID=0, AWADDR=BASE_ADDR, all counters 0.

Source files
------------

// File: rtl/stream_to_ram_ring.sv
// Collects an AXI-Stream into fixed-size blocks and writes each complete block as one
// INCR burst into a RAM region, either stopping when full or overwriting circularly.
module stream_to_ram_ring #(
  parameter int          DW              = 512,
  parameter int          BURST_BEATS     = 64,
  parameter logic [63:0] BASE_ADDR       = 64'h0,
  parameter int          BANK_BLOCKS     = 1024,
  parameter int          WRAP_MODE       = 0,
  parameter int          MAX_OUTSTANDING = 8,
  parameter int          FIFO_DEPTH      = 256
) (
  input  logic            clk,
  input  logic            sys_reset,
  input  logic            enable,
  input  logic [DW-1:0]   AXIS_IN_TDATA,
  input  logic            AXIS_IN_TVALID,
  output logic            AXIS_IN_TREADY,
  output logic [63:0]     M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WVALID,
  output logic            M_AXI_WLAST,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic [31:0]     ram_blocks_written,
  output logic [31:0]     wrap_count,
  output logic [15:0]     bresp_errors,
  output logic            out_of_ram
);

  localparam int SW  = DW / 8;
  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int BW  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [63:0]    BLOCK_BYTES = 64'(BURST_BEATS) * 64'(SW);
  localparam logic [BW-1:0]  LAST_BEAT   = BW'(BURST_BEATS - 1);
  localparam logic [31:0]    BANK_N      = 32'(BANK_BLOCKS);
  localparam logic [31:0]    BANK_LAST   = 32'(BANK_BLOCKS - 1);
  localparam logic [FAW-1:0] PTR_LAST    = FAW'(FIFO_DEPTH - 1);
  localparam logic [FCW-1:0] FIFO_FULL_N = FCW'(FIFO_DEPTH);
  localparam logic [OW-1:0]  OUT_MAX     = OW'(MAX_OUTSTANDING);

  typedef enum logic {AW_IDLE = 1'b0, AW_ADDR = 1'b1} aw_state_t;
  typedef enum logic {W_IDLE = 1'b0, W_BURST = 1'b1} w_state_t;

  function automatic logic [FAW-1:0] ptr_inc(input logic [FAW-1:0] p);
    if (p == PTR_LAST) return {FAW{1'b0}};
    else return p + FAW'(1);
  endfunction

  logic [DW-1:0]  r_mem [FIFO_DEPTH];
  logic [FAW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FCW-1:0] r_count;
  logic [BW-1:0]  r_in_beat;
  logic [31:0]    r_blocks_in;

  aw_state_t      r_aw_state;
  logic           r_awvalid;
  logic [63:0]    r_awaddr;
  logic [31:0]    r_aw_issued;
  logic [31:0]    r_blk_idx;
  logic [31:0]    r_wrap_count;
  logic [OW-1:0]  r_outstanding;

  w_state_t       r_w_state;
  logic [BW-1:0]  r_w_beat;
  logic [31:0]    r_w_issued;

  logic [31:0]    r_blocks_written;
  logic [15:0]    r_bresp_errors;

  logic w_push, w_pop, w_block_done, w_aw_hs, w_b_hs;
  logic w_room, w_aw_pending, w_out_room, w_aw_room;

  // In stop mode the stream is refused once a full region's worth of blocks has arrived.
  assign w_room         = (WRAP_MODE != 0) || (r_blocks_in < BANK_N);
  assign AXIS_IN_TREADY = (r_count != FIFO_FULL_N) && !sys_reset && w_room;
  assign w_push         = AXIS_IN_TVALID && AXIS_IN_TREADY;
  assign w_pop          = M_AXI_WVALID && M_AXI_WREADY;
  assign w_block_done   = w_push && (r_in_beat == LAST_BEAT);
  assign w_aw_hs        = r_awvalid && M_AXI_AWREADY;
  assign M_AXI_BREADY   = !sys_reset;
  assign w_b_hs         = M_AXI_BVALID && M_AXI_BREADY;

  // Look-ahead terms let AWVALID rise the cycle right after a block completes or a B frees a slot.
  assign w_aw_pending = (r_blocks_in != r_aw_issued) || w_block_done;
  assign w_out_room   = (r_outstanding < OUT_MAX) || w_b_hs;
  assign w_aw_room    = (WRAP_MODE != 0) || (r_aw_issued < BANK_N);

  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWLEN   = 8'(BURST_BEATS - 1);
  assign M_AXI_AWSIZE  = 3'($clog2(SW));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WDATA   = r_mem[r_rd_ptr];
  assign M_AXI_WSTRB   = {SW{1'b1}};
  assign M_AXI_WVALID  = (r_w_state == W_BURST) && (r_count != {FCW{1'b0}});
  assign M_AXI_WLAST   = (r_w_state == W_BURST) && (r_w_beat == LAST_BEAT);

  assign ram_blocks_written = r_blocks_written;
  assign wrap_count         = r_wrap_count;
  assign bresp_errors       = r_bresp_errors;
  assign out_of_ram         = (WRAP_MODE == 0) && (r_blocks_written == BANK_N);

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= AXIS_IN_TDATA;
  end

  // FIFO pointers, occupancy and input block tracking
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      r_wr_ptr    <= {FAW{1'b0}};
      r_rd_ptr    <= {FAW{1'b0}};
      r_count     <= {FCW{1'b0}};
      r_in_beat   <= {BW{1'b0}};
      r_blocks_in <= 32'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= ptr_inc(r_wr_ptr);
        r_in_beat <= w_block_done ? {BW{1'b0}} : r_in_beat + BW'(1);
        if (w_block_done) r_blocks_in <= r_blocks_in + 32'd1;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + FCW'(1);
      else if (!w_push && w_pop) r_count <= r_count - FCW'(1);
    end
  end

  // AW channel FSM with ring address generation
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      r_aw_state   <= AW_IDLE;
      r_awvalid    <= 1'b0;
      r_awaddr     <= BASE_ADDR;
      r_aw_issued  <= 32'd0;
      r_blk_idx    <= 32'd0;
      r_wrap_count <= 32'd0;
    end else begin
      case (r_aw_state)
        AW_IDLE: begin
          if (enable && w_aw_pending && w_out_room && w_aw_room) begin
            r_aw_state <= AW_ADDR;
            r_awvalid  <= 1'b1;
          end
        end
        AW_ADDR: begin
          if (M_AXI_AWREADY) begin
            r_aw_state  <= AW_IDLE;
            r_awvalid   <= 1'b0;
            r_aw_issued <= r_aw_issued + 32'd1;
            if (r_blk_idx == BANK_LAST) begin
              r_blk_idx <= 32'd0;
              r_awaddr  <= BASE_ADDR;
              if (WRAP_MODE != 0) r_wrap_count <= r_wrap_count + 32'd1;
            end else begin
              r_blk_idx <= r_blk_idx + 32'd1;
              r_awaddr  <= r_awaddr + BLOCK_BYTES;
            end
          end
        end
        default: begin
          r_aw_state <= AW_IDLE;
          r_awvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Bursts in flight between AW and B
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      r_outstanding <= {OW{1'b0}};
    end else if (w_aw_hs && !w_b_hs) begin
      r_outstanding <= r_outstanding + OW'(1);
    end else if (!w_aw_hs && w_b_hs && (r_outstanding != {OW{1'b0}})) begin
      r_outstanding <= r_outstanding - OW'(1);
    end
  end

  // W channel FSM: back-to-back bursts while granted addresses remain
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      r_w_state  <= W_IDLE;
      r_w_beat   <= {BW{1'b0}};
      r_w_issued <= 32'd0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (r_w_issued != r_aw_issued) begin
            r_w_state <= W_BURST;
            r_w_beat  <= {BW{1'b0}};
          end
        end
        W_BURST: begin
          if (w_pop) begin
            if (r_w_beat == LAST_BEAT) begin
              r_w_beat   <= {BW{1'b0}};
              r_w_issued <= r_w_issued + 32'd1;
              if ((r_aw_issued - r_w_issued) <= 32'd1) r_w_state <= W_IDLE;
            end else begin
              r_w_beat <= r_w_beat + BW'(1);
            end
          end
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  // Write-response statistics
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      r_blocks_written <= 32'd0;
      r_bresp_errors   <= 16'd0;
    end else if (w_b_hs) begin
      r_blocks_written <= r_blocks_written + 32'd1;
      if ((M_AXI_BRESP != 2'b00) && (r_bresp_errors != 16'hFFFF))
        r_bresp_errors <= r_bresp_errors + 16'd1;
    end
  end

endmodule

// File: tb/tb_stream_to_ram_ring.sv
// Bench for stream_to_ram_ring: a stop-mode and a wrap-mode instance share stimulus and are
// compared every cycle against a counting model of accepted beats, AW/W/B handshakes.
module tb_stream_to_ram_ring;
  localparam int          DW   = 64;
  localparam int          BB   = 4;
  localparam int          NB   = 2;
  localparam int          MO   = 2;
  localparam int          FD   = 8;
  localparam int          LOGN = 4096;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_1000;
  localparam logic [63:0] BLK  = 64'd32;

  logic        clk = 1'b0;
  logic        sys_reset, enable, tvalid, awready, wready;
  logic [63:0] tdata;
  logic [1:0]  bresp;

  logic        tready [2];
  logic [63:0] awaddr [2];
  logic [7:0]  awlen  [2];
  logic [2:0]  awsize [2];
  logic [1:0]  awburst[2];
  logic        awvalid[2];
  logic [63:0] wdata  [2];
  logic [7:0]  wstrb  [2];
  logic        wvalid [2];
  logic        wlast  [2];
  logic        bvalid [2];
  logic        bready [2];
  logic [31:0] bw_cnt [2];
  logic [31:0] wrap_cnt[2];
  logic [15:0] berr   [2];
  logic        oor    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    stream_to_ram_ring #(
      .DW(DW), .BURST_BEATS(BB), .BASE_ADDR(BASE), .BANK_BLOCKS(NB),
      .WRAP_MODE(g), .MAX_OUTSTANDING(MO), .FIFO_DEPTH(FD)
    ) u_dut (
      .clk(clk), .sys_reset(sys_reset), .enable(enable),
      .AXIS_IN_TDATA(tdata), .AXIS_IN_TVALID(tvalid), .AXIS_IN_TREADY(tready[g]),
      .M_AXI_AWADDR(awaddr[g]), .M_AXI_AWLEN(awlen[g]), .M_AXI_AWSIZE(awsize[g]),
      .M_AXI_AWBURST(awburst[g]), .M_AXI_AWVALID(awvalid[g]), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata[g]), .M_AXI_WSTRB(wstrb[g]), .M_AXI_WVALID(wvalid[g]),
      .M_AXI_WLAST(wlast[g]), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid[g]), .M_AXI_BREADY(bready[g]),
      .ram_blocks_written(bw_cnt[g]), .wrap_count(wrap_cnt[g]),
      .bresp_errors(berr[g]), .out_of_ram(oor[g])
    );
  end

  always #5 clk = ~clk;

  // reference model: totals of each kind of handshake plus the accepted data log
  int          acc[2], aw[2], wb[2], bc[2], errs[2];
  logic        exp_awv[2];
  logic [63:0] dlog[2][LOGN];

  logic        pv_tv_hs[2], pv_aw_hs[2], pv_w_hs[2], pv_b_hs[2];
  logic        pv_awv[2], pv_wvalid[2], pv_wlast[2];
  logic        pv_rst, pv_en;
  logic [63:0] pv_tdata;
  logic [1:0]  pv_bresp;

  int p_tv, p_awr, p_wr;
  int p_bv[2];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      int   occ;
      logic exp_tr;
      occ    = acc[d] - wb[d];
      exp_tr = !sys_reset && (occ < FD) && ((d == 1) || (acc[d] < NB * BB));
      chk($sformatf("tready%0d", d), 64'(tready[d]), 64'(exp_tr));
      chk($sformatf("awvalid%0d", d), 64'(awvalid[d]), 64'(exp_awv[d]));
      if (awvalid[d])
        chk($sformatf("awaddr%0d", d), awaddr[d], BASE + 64'(aw[d] % NB) * BLK);
      chk($sformatf("bready%0d", d), 64'(bready[d]), 64'(!sys_reset));
      chk($sformatf("blocks_written%0d", d), 64'(bw_cnt[d]), 64'(bc[d]));
      chk($sformatf("wrap_count%0d", d), 64'(wrap_cnt[d]), (d == 1) ? 64'(aw[d] / NB) : 64'd0);
      chk($sformatf("bresp_errors%0d", d), 64'(berr[d]), 64'(errs[d]));
      chk($sformatf("out_of_ram%0d", d), 64'(oor[d]), 64'((d == 0) && (bc[d] == NB)));
      if (occ == 0)
        chk($sformatf("wvalid_empty%0d", d), 64'(wvalid[d]), 64'd0);
      else if ((wb[d] % BB) != 0)
        chk($sformatf("wvalid_midburst%0d", d), 64'(wvalid[d]), 64'd1);
      if (wvalid[d]) begin
        chk($sformatf("wdata%0d", d), wdata[d], dlog[d][wb[d] % LOGN]);
        chk($sformatf("wlast%0d", d), 64'(wlast[d]), 64'((wb[d] % BB) == BB - 1));
        chk($sformatf("w_granted%0d", d), 64'(wb[d] < aw[d] * BB), 64'd1);
      end
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (pv_rst) begin
        acc[d] = 0; aw[d] = 0; wb[d] = 0; bc[d] = 0; errs[d] = 0;
        exp_awv[d] = 1'b0;
      end else begin
        if (pv_tv_hs[d]) begin
          dlog[d][acc[d] % LOGN] = pv_tdata;
          acc[d]++;
        end
        if (pv_aw_hs[d]) aw[d]++;
        if (pv_w_hs[d]) wb[d]++;
        if (pv_b_hs[d]) begin
          bc[d]++;
          if ((pv_bresp != 2'b00) && (errs[d] < 65535)) errs[d]++;
        end
        if (pv_aw_hs[d])  exp_awv[d] = 1'b0;
        else if (pv_awv[d]) exp_awv[d] = 1'b1;
        else exp_awv[d] = pv_en && (acc[d] / BB > aw[d]) && (aw[d] - bc[d] < MO)
                          && ((d == 1) || (aw[d] < NB));
      end
    end
  endtask

  // one clock: drive random inputs, check pre-edge outputs, advance the model
  task automatic step();
    tvalid  = (int'($urandom_range(99)) < p_tv);
    tdata   = {$urandom(), $urandom()};
    awready = (int'($urandom_range(99)) < p_awr);
    wready  = (int'($urandom_range(99)) < p_wr);
    bresp   = ($urandom_range(3) == 0) ? 2'b10 : 2'b00;
    for (int d = 0; d < 2; d++)
      bvalid[d] = (aw[d] > bc[d]) && (int'($urandom_range(99)) < p_bv[d]);
    #1;
    check_outputs();
    pv_rst = sys_reset; pv_en = enable; pv_tdata = tdata; pv_bresp = bresp;
    for (int d = 0; d < 2; d++) begin
      pv_tv_hs[d]  = tvalid && tready[d];
      pv_aw_hs[d]  = awvalid[d] && awready;
      pv_w_hs[d]   = wvalid[d] && wready;
      pv_b_hs[d]   = bvalid[d] && bready[d];
      pv_awv[d]    = awvalid[d];
      pv_wvalid[d] = wvalid[d];
      pv_wlast[d]  = wlast[d];
    end
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    sys_reset = 1'b1; enable = 1'b0; tvalid = 1'b0; tdata = 64'd0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00;
    p_tv = 0; p_awr = 0; p_wr = 0;
    for (int d = 0; d < 2; d++) begin
      bvalid[d] = 1'b0; p_bv[d] = 0;
      acc[d] = 0; aw[d] = 0; wb[d] = 0; bc[d] = 0; errs[d] = 0;
      exp_awv[d] = 1'b0; pv_wvalid[d] = 1'b0; pv_awv[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    run(2);
    for (int d = 0; d < 2; d++) begin
      chk("awlen", 64'(awlen[d]), 64'd3);
      chk("awsize", 64'(awsize[d]), 64'd3);
      chk("awburst", 64'(awburst[d]), 64'd1);
      chk("wstrb", 64'(wstrb[d]), 64'hFF);
      chk("reset_awaddr", awaddr[d], BASE);
    end
    sys_reset = 1'b0;
    enable    = 1'b1;

    // two complete blocks wait behind a stalled AW channel, then stream out back to back
    p_awr = 0; p_wr = 100; p_bv[0] = 100; p_bv[1] = 100; p_tv = 100;
    n = 0;
    while (acc[0] < 2 * BB && n < 50) begin step(); n++; end
    chk("fill_timeout", 64'(n < 50), 64'd1);
    p_tv = 0;
    run(2);
    chk("aw_waiting", 64'(pv_awv[0]), 64'd1);
    p_awr = 100;
    n = 0;
    while (!pv_wvalid[0] && n < 30) begin step(); n++; end
    chk("w_start_timeout", 64'(n < 30), 64'd1);
    for (int k = 0; k < 2 * BB; k++) begin
      chk("w_consecutive", 64'(pv_wvalid[0]), 64'd1);
      chk("w_last_position", 64'(pv_wlast[0]), 64'((k == BB - 1) || (k == 2 * BB - 1)));
      step();
    end
    run(30);
    chk("stop_aw_count", 64'(aw[0]), 64'd2);
    chk("stop_out_of_ram", 64'(oor[0]), 64'd1);
    chk("stop_blocks_written", 64'(bw_cnt[0]), 64'd2);

    // four more beats: the stop instance refuses them, the ring instance wraps to BASE
    p_tv = 100;
    n = 0;
    while (acc[1] < 3 * BB && n < 60) begin step(); n++; end
    chk("wrap_fill_timeout", 64'(n < 60), 64'd1);
    p_tv = 0;
    run(40);
    chk("stop_accepted", 64'(acc[0]), 64'd8);
    chk("wrap_aw_count", 64'(aw[1]), 64'd3);
    chk("wrap_count_one", 64'(wrap_cnt[1]), 64'd1);
    chk("wrap_out_of_ram", 64'(oor[1]), 64'd0);
    chk("wrap_blocks_written", 64'(bw_cnt[1]), 64'd3);

    // outstanding limit with B withheld
    sys_reset = 1'b1; run(2); sys_reset = 1'b0;
    p_bv[0] = 0; p_bv[1] = 0; p_awr = 100; p_wr = 100; p_tv = 100;
    n = 0;
    while (acc[1] < 4 * BB && n < 100) begin step(); n++; end
    chk("outst_fill_timeout", 64'(n < 100), 64'd1);
    p_tv = 0;
    run(10);
    chk("max_outstanding_wrap", 64'(aw[1]), 64'd2);
    chk("max_outstanding_stop", 64'(aw[0]), 64'd2);
    p_bv[1] = 100; step(); p_bv[1] = 0; step();
    chk("aw_after_first_b", 64'(pv_awv[1]), 64'd1);
    p_bv[0] = 100; p_bv[1] = 100;
    run(40);
    chk("outst_aw_total", 64'(aw[1]), 64'd4);
    chk("outst_blocks_written", 64'(bw_cnt[1]), 64'd4);
    chk("outst_wrap_count", 64'(wrap_cnt[1]), 64'd2);

    // reset while the second beat of a burst is on the bus
    sys_reset = 1'b1; step(); sys_reset = 1'b0;
    p_tv = 100; p_awr = 100; p_wr = 100;
    n = 0;
    while (!((wb[0] % BB == 1) && (acc[0] > wb[0])) && n < 60) begin step(); n++; end
    chk("midburst_timeout", 64'(n < 60), 64'd1);
    sys_reset = 1'b1; step(); sys_reset = 1'b0; step();
    chk("rst_wvalid", 64'(pv_wvalid[0]), 64'd0);
    chk("rst_awaddr", awaddr[0], BASE);
    chk("rst_blocks_written", 64'(bw_cnt[0]), 64'd0);
    chk("rst_wrap_count", 64'(wrap_cnt[1]), 64'd0);

    // randomized traffic with enable toggling, back-pressure and occasional resets
    for (int e = 0; e < 16; e++) begin
      p_tv    = int'($urandom_range(100));
      p_awr   = int'($urandom_range(100));
      p_wr    = int'($urandom_range(100));
      p_bv[0] = int'($urandom_range(100));
      p_bv[1] = int'($urandom_range(100));
      enable  = ($urandom_range(3) != 0);
      if (e % 4 == 3) begin
        sys_reset = 1'b1; step(); sys_reset = 1'b0;
      end
      run(100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
